// File: rtl/game_pkg.sv
// Shared types and constants for the word-scramble game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE_SEL,
        ST_WAIT_WORD,
        ST_PLAY,
        ST_SHOW_ROUND,
        ST_SHOW_TOTAL,
        ST_FINAL
    } state_t;

    localparam logic [2:0] CS_BLANK = 3'b000;
    localparam logic [2:0] CS_MODE  = 3'b001;
    localparam logic [2:0] CS_SCRAM = 3'b010;
    localparam logic [2:0] CS_ROUND = 3'b011;
    localparam logic [2:0] CS_TOTAL = 3'b100;
    localparam logic [2:0] CS_FINAL = 3'b101;

    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    function automatic int cnt_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] cs_of(state_t s);
        case (s)
            ST_MODE_SEL:   return CS_MODE;
            ST_PLAY:       return CS_SCRAM;
            ST_SHOW_ROUND: return CS_ROUND;
            ST_SHOW_TOTAL: return CS_TOTAL;
            ST_FINAL:      return CS_FINAL;
            default:       return CS_BLANK;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(logic [1:0] m);
        case (m)
            2'd1:    return SEG_1;
            2'd2:    return SEG_2;
            2'd3:    return SEG_3;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector; the history flop resets high so a button
// held through reset is not seen as a press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev_q, prev_d;

    always_comb begin
        prev_d = btn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b1;
        else     prev_q <= prev_d;
    end

    assign press = btn & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Word-scramble game sequencer: mode select, rounds, score screens.
// GAME_CTRL_TIMEOUT_EN adds the per-round timer and timeout pulse.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SHOW_CYCLES = 100_000_000,
    parameter int TIME_LIMIT  = 1_500_000_000,
    parameter int ROUNDS      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_submit,
    input  logic       word_ready,
    output logic [2:0] controlSig,
    output logic [7:0] modeDisp,
    output logic [1:0] mode,
    output logic [3:0] round,
    output logic       word_req,
    output logic       timeout
);

    localparam int SW = cnt_w(SHOW_CYCLES);
    localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
    localparam logic [3:0] ROUND_MAX = 4'(ROUNDS);

    logic start_p, mode_p, sub_p, expire;

    btn_edge u_start (.clk(clk), .rst(rst), .btn(btn_start),  .press(start_p));
    btn_edge u_mode  (.clk(clk), .rst(rst), .btn(btn_mode),   .press(mode_p));
    btn_edge u_sub   (.clk(clk), .rst(rst), .btn(btn_submit), .press(sub_p));

    state_t state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] round_q, round_d;
    logic [SW-1:0] show_q, show_d;
    logic word_req_q, word_req_d;
    logic timeout_q, timeout_d;
    logic [2:0] cs_q;
    logic [7:0] seg_q;

`ifdef GAME_CTRL_TIMEOUT_EN
    localparam int TW = cnt_w(TIME_LIMIT);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIME_LIMIT - 1);

    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (state_q == ST_WAIT_WORD) timer_d = '0;
        else if (state_q == ST_PLAY) timer_d = timer_q + TW'(1);
    end

    assign expire = (state_q == ST_PLAY) && (timer_q == TIME_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        round_d    = round_q;
        show_d     = show_q;
        word_req_d = 1'b0;
        timeout_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d = ST_MODE_SEL;
                    mode_d  = 2'd1;
                end
            end
            ST_MODE_SEL: begin
                if (start_p) begin
                    state_d    = ST_WAIT_WORD;
                    round_d    = '0;
                    word_req_d = 1'b1;
                end else if (mode_p) begin
                    mode_d = (mode_q == 2'd3) ? 2'd1 : mode_q + 2'd1;
                end
            end
            ST_WAIT_WORD: begin
                if (word_ready) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // submit takes priority over a simultaneous expiry
                if (sub_p || expire) begin
                    state_d   = ST_SHOW_ROUND;
                    timeout_d = expire & ~sub_p;
                    if (round_q != ROUND_MAX) round_d = round_q + 4'd1;
                end
            end
            ST_SHOW_ROUND: begin
                show_d = show_q + SW'(1);
                if (show_q == SHOW_LAST) begin
                    show_d = '0;
                    if (round_q == ROUND_MAX) begin
                        state_d = ST_SHOW_TOTAL;
                    end else begin
                        state_d    = ST_WAIT_WORD;
                        word_req_d = 1'b1;
                    end
                end
            end
            ST_SHOW_TOTAL: begin
                show_d = show_q + SW'(1);
                if (show_q == SHOW_LAST) begin
                    show_d  = '0;
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (start_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd1;
            round_q    <= '0;
            show_q     <= '0;
            word_req_q <= 1'b0;
            timeout_q  <= 1'b0;
            cs_q       <= CS_BLANK;
            seg_q      <= SEG_1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            round_q    <= round_d;
            show_q     <= show_d;
            word_req_q <= word_req_d;
            timeout_q  <= timeout_d;
            cs_q       <= cs_of(state_d);
            seg_q      <= seg_of(mode_d);
        end
    end

    assign controlSig = cs_q;
    assign modeDisp   = seg_q;
    assign mode       = mode_q;
    assign round      = round_q;
    assign word_req   = word_req_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed game walk-throughs plus random buttons,
// every cycle compared against a screen-level game model.
module tb_game_ctrl;

    localparam int SC = 4;
    localparam int TL = 10;
    localparam int NR = 2;
`ifdef GAME_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_start = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_submit = 1'b0;
    logic word_ready = 1'b0;
    logic [2:0] controlSig;
    logic [7:0] modeDisp;
    logic [1:0] mode;
    logic [3:0] round;
    logic word_req;
    logic timeout;

    game_ctrl #(
        .SHOW_CYCLES(SC),
        .TIME_LIMIT(TL),
        .ROUNDS(NR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .btn_mode(btn_mode),
        .btn_submit(btn_submit),
        .word_ready(word_ready),
        .controlSig(controlSig),
        .modeDisp(modeDisp),
        .mode(mode),
        .round(round),
        .word_req(word_req),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef enum {M_OFF, M_PICK, M_FETCH, M_GUESS, M_RSCORE, M_TSCORE, M_END} phase_t;
    phase_t ph;
    int m_mode, m_round, m_left, m_age;
    bit m_wreq, m_to;
    bit p_s, p_m, p_b;
    logic [7:0] seg_tab [1:3] = '{8'hF9, 8'hA4, 8'hB0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cs();
        case (ph)
            M_PICK:   return 1;
            M_GUESS:  return 2;
            M_RSCORE: return 3;
            M_TSCORE: return 4;
            M_END:    return 5;
            default:  return 0;
        endcase
    endfunction

    task automatic model_reset();
        ph = M_OFF;
        m_mode = 1;
        m_round = 0;
        m_left = 0;
        m_age = 0;
        m_wreq = 0;
        m_to = 0;
        p_s = 1;
        p_m = 1;
        p_b = 1;
    endtask

    task automatic model_edge(input bit s, input bit m, input bit b, input bit w);
        bit ps, pm, pb;
        ps = s && !p_s;
        pm = m && !p_m;
        pb = b && !p_b;
        m_wreq = 0;
        m_to = 0;
        case (ph)
            M_OFF: if (ps) begin ph = M_PICK; m_mode = 1; end
            M_PICK: begin
                if (ps) begin
                    ph = M_FETCH;
                    m_round = 0;
                    m_wreq = 1;
                end else if (pm) begin
                    m_mode = m_mode % 3 + 1;
                end
            end
            M_FETCH: if (w) begin ph = M_GUESS; m_age = 0; end
            M_GUESS: begin
                m_age++;
                if (pb || (TO_EN && m_age == TL)) begin
                    m_to = !pb;
                    ph = M_RSCORE;
                    m_left = SC;
                    if (m_round < NR) m_round++;
                end
            end
            M_RSCORE: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_round == NR) begin
                        ph = M_TSCORE;
                        m_left = SC;
                    end else begin
                        ph = M_FETCH;
                        m_wreq = 1;
                    end
                end
            end
            M_TSCORE: begin
                m_left--;
                if (m_left == 0) ph = M_END;
            end
            M_END: if (ps) ph = M_OFF;
            default: ph = M_OFF;
        endcase
        p_s = s;
        p_m = m;
        p_b = b;
    endtask

    task automatic compare_all();
        check("ctrl", controlSig, exp_cs());
        check("mode", mode, m_mode);
        check("seg", modeDisp, seg_tab[m_mode]);
        check("round", round, m_round);
        check("wreq", word_req, m_wreq);
        check("tout", timeout, m_to);
    endtask

    task automatic step(input bit s, input bit m, input bit b, input bit w);
        btn_start = s;
        btn_mode = m;
        btn_submit = b;
        word_ready = w;
        @(posedge clk);
        model_edge(s, m, b, w);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        btn_start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compare_all();
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
        end
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (14) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (12) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 20 && ph == M_GUESS && m_age < TL - 1; i++)
            step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        async_reset();

        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (1000) step(0, 0, 0, 0);

        async_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the word-scramble game. It generates the 3-bit display-select code and the mode digit consumed by the six-digit display multiplexer, and requests new scrambled words from the scrambler. It tracks rounds, times each round, and sequences the round-score, total-score and final screens. It is the initiator of the display-select interface; the multiplexer is the responder.

## Interface
- SHOW_CYCLES, 100_000_000: cycles each score screen is held (2 s at 50 MHz)
- TIME_LIMIT, 1_500_000_000: cycles allowed per round before timeout
- ROUNDS, 5: rounds per game (1–15)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- btn_start  in  1  debounced, synchronous level, active-high
- btn_mode  in  1  debounced, synchronous level, active-high
- btn_submit  in  1  debounced, synchronous level, active-high
- word_ready  in  1  scrambler has a new word on Scram0..5
- controlSig  out  3  display-select code to the multiplexer
- modeDisp  out  8  active-low segments {dp,g..a} of the mode digit
- mode  out  2  selected mode, 1..3
- round  out  4  completed rounds in the current game
- word_req  out  1  one-cycle pulse requesting a new word
- timeout  out  1  one-cycle pulse when a round expires

## Operation
- Press = rising edge of a button: high this cycle, low the previous cycle. Edge registers reset to 1, so a button held through reset is not a press.
- Each state has one controlSig code:
  - IDLE = 000
  - MODE_SEL = 001
  - WAIT_WORD = 000
  - PLAY = 010
  - SHOW_ROUND = 011
  - SHOW_TOTAL = 100
  - FINAL = 101
- IDLE: start → MODE_SEL; mode set to 1.
- MODE_SEL:
  - mode press cycles mode 1→2→3→1.
  - start press → WAIT_WORD; round cleared to 0; word_req pulsed.
  - If mode and start are pressed in the same cycle, start wins.
- WAIT_WORD: waits for word_ready high → PLAY; round timer cleared.
- PLAY:
  - submit press → SHOW_ROUND; round increments.
  - If the timer reaches TIME_LIMIT-1 → timeout pulses for one cycle, then the same path as submit.
  - If submit and expiry occur in the same cycle, submit wins and timeout is not pulsed.
- SHOW_ROUND: held SHOW_CYCLES cycles, then:
  - if round == ROUNDS → SHOW_TOTAL;
  - else → WAIT_WORD, with word_req pulsed.
- SHOW_TOTAL: held SHOW_CYCLES cycles → FINAL.
- FINAL: start press → IDLE. All other buttons are ignored.
- Buttons pressed in states where they have no action are ignored.
- modeDisp: 1 = 8'hF9, 2 = 8'hA4, 3 = 8'hB0.
- round saturates at ROUNDS.

## Timing
- All outputs are registered.
- controlSig, mode, modeDisp and round change on the clock edge that samples the press or condition. The new value is visible the cycle after the first high sample.
- word_req is asserted in the first cycle of WAIT_WORD only.
- Screen counters count 0..SHOW_CYCLES-1, so each screen lasts exactly SHOW_CYCLES cycles.
- Reset values:
  - state IDLE, controlSig 000
  - mode 1, modeDisp 8'hF9
  - round 0
  - word_req 0, timeout 0
  - all counters 0
- Reset mid-game returns to IDLE immediately (asynchronous); no word_req is issued.
- A word_ready already high on entry to WAIT_WORD moves to PLAY on the next edge.

## Configuration
- GAME_CTRL_TIMEOUT_EN:
  - Defined: round timer present; timeout path active.
  - Undefined: no timer logic; PLAY waits for submit indefinitely; timeout is tied to 0.

## Structure
- game_pkg holds:
  - state enum;
  - controlSig code localparams (CS_BLANK, CS_MODE, CS_SCRAM, CS_ROUND, CS_TOTAL, CS_FINAL);
  - segment constants SEG_1/SEG_2/SEG_3 and SEG_DASH = 8'hBF.
- Sub-module btn_edge (rising-edge detector with reset-to-1 register), instantiated once per button.
- Counter widths are $clog2 of the parameters.

## Test plan
Run with SHOW_CYCLES=4, TIME_LIMIT=10, ROUNDS=2.
- Reset, then hold btn_start high → no press detected; controlSig stays 000. Release, then press → controlSig 001, modeDisp 8'hF9.
- In MODE_SEL, press mode 3 times → mode 2, 3, 1; modeDisp A4, B0, F9. Press start → word_req high exactly 1 cycle, controlSig 000.
- Raise word_ready → controlSig 010. Press submit at cycle 3 → controlSig 011 for 4 cycles, round 1, then word_req pulse.
- Idle in PLAY → timeout pulses on cycle 10, round 2, then 011 (4 cycles), 100 (4 cycles), 101. Start press → 000.
- Submit on the exact expiry cycle → no timeout pulse; round increments once.
- Assert rst during SHOW_ROUND → all outputs return to reset values immediately. Compiled without GAME_CTRL_TIMEOUT_EN → PLAY held 1000 cycles, no timeout.
